// File: rtl/demux_sched_if.sv
// Serial-source and demux-side signals of the demux_sched round-robin scheduler.
// The slave modport is the scheduler; the master modport is the source/observer.
interface demux_sched_if;
    logic in_valid;
    logic in_data;
    logic in_ready;
    logic d;
    logic s0;
    logic s1;
    logic s2;
    logic d_valid;

    modport master (
        output in_valid, in_data,
        input  in_ready, d, s0, s1, s2, d_valid
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, d, s0, s1, s2, d_valid
    );
endinterface

// File: rtl/demux_sched.sv
// Round-robin scheduler feeding a 1:8 serial demux in bursts of BURST_LEN bits.
// Optional stall timeout is enabled with the DEMUX_SCHED_TIMEOUT_EN macro.
module demux_sched #(
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic [7:0]      en_mask,
    input  logic [7:0]      ch_ready,
    output logic            busy,
    output logic            timeout_flag,
    demux_sched_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        XFER   = 2'd2
    } state_t;

    localparam logic [7:0] LAST_BIT = 8'(BURST_LEN - 1);

    state_t     state;
    logic [2:0] sel;
    logic [2:0] ptr;
    logic [7:0] cnt;
    logic       d_r;
    logic       d_valid_r;
    logic [7:0] eligible;
    logic [3:0] pick;
    logic       in_ready_c;
    logic       xfer;

    // Returns {found, channel}: first eligible channel scanning upward from base, wrapping 7->0.
    function automatic logic [3:0] rr_pick(input logic [7:0] elig, input logic [2:0] base);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            idx = base + 3'(k);
            if (elig[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Channel search and handshake decode for the current cycle.
    always_comb begin
        eligible   = en_mask & ch_ready;
        pick       = rr_pick(eligible, ptr);
        in_ready_c = (state == XFER) ? (ch_ready[sel] & en_mask[sel]) : 1'b0;
        xfer       = in_ready_c & bus.in_valid;
    end

    assign bus.in_ready = in_ready_c;
    assign bus.d        = d_r;
    assign bus.d_valid  = d_valid_r;
    assign bus.s0       = sel[0];
    assign bus.s1       = sel[1];
    assign bus.s2       = sel[2];
    assign busy         = (state != IDLE);

`ifdef DEMUX_SCHED_TIMEOUT_EN
    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT - 1);
    logic [15:0] stall;
    logic        timeout_r;
    assign timeout_flag = timeout_r;
`else
    assign timeout_flag = 1'b0;
`endif

    // Scheduler state machine with registered demux outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= 3'd0;
            ptr       <= 3'd0;
            cnt       <= 8'd0;
            d_r       <= 1'b0;
            d_valid_r <= 1'b0;
`ifdef DEMUX_SCHED_TIMEOUT_EN
            stall     <= 16'd0;
            timeout_r <= 1'b0;
`endif
        end else begin
            d_r       <= xfer ? bus.in_data : 1'b0;
            d_valid_r <= xfer;
`ifdef DEMUX_SCHED_TIMEOUT_EN
            if (start) begin
                timeout_r <= 1'b0;
            end
`endif
            case (state)
                IDLE: begin
                    if (!stop && start) begin
                        state <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (pick[3]) begin
                        sel   <= pick[2:0];
                        cnt   <= 8'd0;
                        state <= XFER;
`ifdef DEMUX_SCHED_TIMEOUT_EN
                        stall <= 16'd0;
`endif
                    end
                end
                XFER: begin
                    if (xfer) begin
                        if (cnt == LAST_BIT) begin
                            cnt   <= 8'd0;
                            ptr   <= sel + 3'd1;
                            state <= SEARCH;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
`ifdef DEMUX_SCHED_TIMEOUT_EN
                    // Stall counts only cycles where the selected channel refuses data.
                    if (xfer) begin
                        stall <= 16'd0;
                    end else if (!in_ready_c) begin
                        if (stall == STALL_LAST) begin
                            stall     <= 16'd0;
                            ptr       <= sel + 3'd1;
                            state     <= SEARCH;
                            timeout_r <= 1'b1;
                        end else begin
                            stall <= stall + 16'd1;
                        end
                    end
`endif
                    if (stop) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_demux_sched.sv
// Randomized scoreboard bench for demux_sched against a burst-level reference model.
module tb_demux_sched;
    localparam int BL = 4;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic [7:0] en_mask;
    logic [7:0] ch_ready;
    logic       busy;
    logic       timeout_flag;

    demux_sched_if bus ();

    demux_sched #(.BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .en_mask      (en_mask),
        .ch_ready     (ch_ready),
        .busy         (busy),
        .timeout_flag (timeout_flag),
        .bus          (bus.slave)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Expected deliveries: {data, channel}
    logic [3:0] exp_q[$];
    logic [3:0] e;

    // Reference model: 0 = idle, 1 = searching, 2 = delivering a burst
    int m_mode  = 0;
    int m_ptr   = 0;
    int m_sel   = 0;
    int m_cnt   = 0;
    int m_stall = 0;
    bit m_flag  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit st, input bit sp,
                        input logic [7:0] em, input logic [7:0] cr,
                        input bit v, input bit dat);
        bit         rdy;
        bit         xf;
        logic [7:0] el;
        @(negedge clk);
        rst = r; start = st; stop = sp; en_mask = em; ch_ready = cr;
        bus.in_valid = v; bus.in_data = dat;
        #1;
        if (r) begin
            m_mode = 0; m_ptr = 0; m_sel = 0; m_cnt = 0; m_stall = 0; m_flag = 1'b0;
            exp_q.delete();
            check("in_ready_in_reset", bus.in_ready, 0);
            return;
        end
        rdy = (m_mode == 2) && cr[m_sel] && em[m_sel];
        check("in_ready", bus.in_ready, rdy);
        xf = rdy && v;
        if (xf) exp_q.push_back({dat, 3'(m_sel)});
        if (st) m_flag = 1'b0;
        el = em & cr;
        case (m_mode)
            0: if (!sp && st) m_mode = 1;
            1: begin
                if (sp) m_mode = 0;
                else if (el != 8'h00) begin
                    for (int k = 7; k >= 0; k--)
                        if (el[(m_ptr + k) % 8]) m_sel = (m_ptr + k) % 8;
                    m_cnt = 0; m_stall = 0; m_mode = 2;
                end
            end
            default: begin
                if (xf) begin
                    m_cnt++;
                    m_stall = 0;
                    if (m_cnt == BL) begin
                        m_ptr = (m_sel + 1) % 8;
                        m_mode = 1;
                    end
                end
`ifdef DEMUX_SCHED_TIMEOUT_EN
                else if (!rdy) begin
                    m_stall++;
                    if (m_stall == TO) begin
                        m_ptr = (m_sel + 1) % 8;
                        m_mode = 1;
                        m_flag = 1'b1;
                    end
                end
`endif
                if (sp) m_mode = 0;
            end
        endcase
    endtask

    // Monitor: compares registered outputs just after each active edge.
    always @(posedge clk) begin
        #1;
        if (bus.d_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_d_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("d", bus.d, e[3]);
                check("sel_on_valid", {bus.s2, bus.s1, bus.s0}, e[2:0]);
            end
        end else begin
            check("d_zero_when_invalid", bus.d, 0);
        end
        check("busy", busy, m_mode != 0);
        check("sel_hold", {bus.s2, bus.s1, bus.s0}, m_sel);
        check("timeout_flag", timeout_flag, m_flag);
    end

    initial begin
        bit r, st, sp, v;
        logic [7:0] em, cr;
        rst = 1'b1; start = 1'b0; stop = 1'b0; en_mask = 8'h00; ch_ready = 8'h00;
        bus.in_valid = 1'b0; bus.in_data = 1'b0;
        step(1, 0, 0, 8'hFF, 8'hFF, 0, 0);
        step(1, 0, 0, 8'hFF, 8'hFF, 0, 0);

        // Full rotation over all eight channels with alternating data
        step(0, 1, 0, 8'hFF, 8'hFF, 0, 0);
        for (int i = 0; i < 44; i++) step(0, 0, 0, 8'hFF, 8'hFF, 1, i[0]);
        step(0, 0, 1, 8'hFF, 8'hFF, 0, 0);

        // Only channels 2 and 5 enabled
        step(0, 1, 0, 8'h24, 8'hFF, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 8'h24, 8'hFF, 1, 1'($urandom));
        step(0, 0, 1, 8'h24, 8'hFF, 0, 0);

        // Mid-burst stall on channel 3
        step(1, 0, 0, 8'h08, 8'hFF, 0, 0);
        step(0, 1, 0, 8'h08, 8'hFF, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h08, 8'hFF, 1, 1'($urandom));
        for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h08, 8'hF7, 1, 1'($urandom));
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h08, 8'hFF, 1, 1'($urandom));
        step(0, 0, 1, 8'h08, 8'hFF, 0, 0);

        // Wrap from channel 7 to itself, then to channel 0
        step(1, 0, 0, 8'h80, 8'hFF, 0, 0);
        step(0, 1, 0, 8'h80, 8'hFF, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 8'h80, 8'hFF, 1, 1'($urandom));
        for (int i = 0; i < 12; i++) step(0, 0, 0, 8'h81, 8'hFF, 1, 1'($urandom));
        step(0, 0, 1, 8'h81, 8'hFF, 0, 0);

        // Stop on the second bit of a burst, then resume
        step(1, 0, 0, 8'hFF, 8'hFF, 0, 0);
        step(0, 1, 0, 8'hFF, 8'hFF, 0, 0);
        step(0, 0, 0, 8'hFF, 8'hFF, 1, 1);
        step(0, 0, 0, 8'hFF, 8'hFF, 1, 0);
        step(0, 0, 1, 8'hFF, 8'hFF, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'hFF, 8'hFF, 1, 1);
        step(0, 1, 0, 8'hFF, 8'hFF, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 8'hFF, 8'hFF, 1, 1'($urandom));
        step(0, 0, 1, 8'hFF, 8'hFF, 0, 0);

        // Long stall on channel 0 (timeout behaviour depends on build)
        step(1, 0, 0, 8'hFF, 8'hFF, 0, 0);
        step(0, 1, 0, 8'hFF, 8'hFF, 0, 0);
        step(0, 0, 0, 8'hFF, 8'hFF, 1, 1);
        step(0, 0, 0, 8'hFF, 8'hFF, 1, 1);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 8'hFF, 8'hFE, 1, 1'($urandom));
        for (int i = 0; i < 10; i++) step(0, 0, 0, 8'hFF, 8'hFF, 1, 1'($urandom));
        step(0, 0, 1, 8'hFF, 8'hFF, 0, 0);

        // Randomized traffic
        em = 8'hFF;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) em = 8'($urandom);
            cr = 8'($urandom) | 8'($urandom);
            r  = ($urandom_range(0, 399) == 0);
            st = ($urandom_range(0, 29) == 0);
            sp = ($urandom_range(0, 59) == 0);
            v  = ($urandom_range(0, 9) < 8);
            step(r, st, sp, em, cr, v, 1'($urandom));
        end

        for (int i = 0; i < 4; i++) step(0, 0, 1, 8'hFF, 8'hFF, 0, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
